uart_pixel_loader: RTL and testbench
====================================

# uart_pixel_loader

Receives an image over a UART serial line and writes it, pixel by pixel, into the write port of the screen-buffer block RAM. The VGA scan-out stage reads that same RAM, so images can be replaced at runtime instead of only at synthesis time through the hex file. The block contains an 8N1 UART receiver and a framing state machine that turns received bytes into sequential 6-bit pixel writes.

## Interface
Parameters:
- CLK_HZ, 27000000: system clock frequency.
- BAUD, 115200: serial bit rate.
- IMAGE_SOURCE_X, 100: image width in pixels.
- IMAGE_SOURCE_Y, 100: image height in lines.
- MEMORY_ADDRESS_BITS, 14: width of the RAM write address.
- SYNC_BYTE, 8'hA5: byte that starts a frame.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock shared with the VGA timing.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART input, idle high.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  MEMORY_ADDRESS_BITS  RAM write address, computed as y*IMAGE_SOURCE_X + x.
- wr_data  out  6  pixel value {r[1:0], g[1:0], b[1:0]}.
- busy  out  1  high while a frame is being loaded.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- framing_error  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- DIV = CLK_HZ / BAUD, using integer division that truncates. HALF = DIV / 2. NPIX = IMAGE_SOURCE_X * IMAGE_SOURCE_Y.
- rx passes through a two-flop synchronizer. Both flops reset to 1.
- RX state machine states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a falling edge on the synchronized rx moves to START and clears the bit timer.
  - START: after HALF cycles, sample rx.
    - If rx is low, go to DATA with the bit index at 0.
    - If rx is high, treat it as a glitch and return to IDLE.
  - DATA: every DIV cycles, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after DIV cycles, sample rx.
    - If rx is high, raise the internal byte_valid for one cycle and return to IDLE.
    - If rx is low, pulse framing_error, drop the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized rx is high, then go to IDLE.
- Frame state machine states: HUNT, LOAD.
  - HUNT: busy is 0. A byte_valid carrying SYNC_BYTE moves to LOAD and clears the address counter. All other bytes are ignored.
  - LOAD: busy is 1. The response to byte_valid depends on the byte b:
    - b[7:6] == 2'b00: drive wr_en=1, wr_data=b[5:0], wr_addr=current address, then increment the address.
    - b == SYNC_BYTE: restart the frame. The address returns to 0 and nothing is written.
    - Any other byte: drop it. Nothing is written and the address does not advance.
  - After the write at address NPIX-1: return to HUNT and pulse frame_done on the next cycle.
- The address counter never exceeds NPIX-1, so there is no wrap-around inside a frame.
- Writes occur at most once per received byte, about 10*DIV cycles apart. The RAM always accepts them; there is no backpressure.
- Reset mid-operation: both state machines return to IDLE/HUNT and the partially received byte is lost. RAM contents already written are kept, and the next frame starts from address 0.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, framing_error=0.
  - Synchronizer flops = 1, bit timer = 0.
- Synchronizer latency: 2 cycles.
- Sample points:
  - Start bit is sampled HALF cycles after the edge is detected.
  - Data bit n is sampled HALF + (n+1)*DIV cycles after the edge.
  - Stop bit is sampled HALF + 9*DIV cycles after the edge.
- byte_valid (internal) is high in the cycle after the stop bit is sampled.
- wr_en, wr_addr and wr_data are registered and valid in the cycle after byte_valid. They hold for exactly one cycle.
- busy rises in the cycle after the SYNC_BYTE byte_valid. It falls in the same cycle as the last wr_en, because busy is registered together with it.
- frame_done is high for the one cycle after the last wr_en.
- framing_error is high in the cycle after the failing stop-bit sample.

## Test plan
Bench parameters: CLK_HZ=1000000, BAUD=100000 (DIV=10), image 4x2 (NPIX=8).
- Reset, then drive rx idle for 200 cycles -> all outputs stay 0 and busy=0.
- Send A5 followed by 00, 01, ..., 07 -> eight wr_en pulses at wr_addr 0..7 with wr_data 0..7, spaced 100 cycles apart. frame_done pulses once, one cycle after the addr-7 write, and busy=0 afterwards.
- Send 3F without a preceding A5, then A5 followed by 3F -> no write for the first 3F; a single write of addr 0, data 3F.
- Send A5, 01, 02, then A5 again, then 8 pixels of value 15 -> writes go to addr 0 and 1, then restart at addr 0 and continue through addr 7 with data 15.
- Send A5, then a pixel byte whose stop bit is held low, then rx high, then 8 valid pixels -> one framing_error pulse, no write for the corrupted byte, and addr 0..7 written in order.
- Send A5 and 3 pixels, assert rst for 1 cycle, then send A5 and 8 pixels -> after reset busy=0 and wr_addr=0, and the new frame writes addr 0..7.
- Hold rx low for 3 cycles only (glitch) -> the receiver returns to IDLE and no byte and no error are produced.

Source files
------------

// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: 8N1 UART receiver plus a framing FSM that turns
// received bytes into sequential 6-bit pixel writes into the screen RAM.
module uart_pixel_loader #(
  parameter int unsigned CLK_HZ              = 27000000,
  parameter int unsigned BAUD                = 115200,
  parameter int unsigned IMAGE_SOURCE_X      = 100,
  parameter int unsigned IMAGE_SOURCE_Y      = 100,
  parameter int unsigned MEMORY_ADDRESS_BITS = 14,
  parameter logic [7:0]  SYNC_BYTE           = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx,
  output logic                           wr_en,
  output logic [MEMORY_ADDRESS_BITS-1:0] wr_addr,
  output logic [5:0]                     wr_data,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           framing_error
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned NPIX = IMAGE_SOURCE_X * IMAGE_SOURCE_Y;
  localparam int unsigned TW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
  localparam logic [MEMORY_ADDRESS_BITS-1:0] LAST_ADDR = MEMORY_ADDRESS_BITS'(NPIX - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    F_HUNT,
    F_LOAD
  } frame_state_t;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic      rx_s1, rx_s2, rx_d;
  rx_state_t rx_state, rx_state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [7:0] shreg, shreg_next;
  logic       byte_valid, byte_valid_next;
  logic       fe_next;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_state      <= rx_state_next;
      timer         <= timer_next;
      bit_idx       <= bit_idx_next;
      shreg         <= shreg_next;
      byte_valid    <= byte_valid_next;
      framing_error <= fe_next;
    end
  end

  // Receiver next-state: bit timing, sampling and stop-bit validation
  always_comb begin
    rx_state_next   = rx_state;
    timer_next      = timer + TW'(1);
    bit_idx_next    = bit_idx;
    shreg_next      = shreg;
    byte_valid_next = 1'b0;
    fe_next         = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        timer_next = '0;
        if (rx_d && !rx_s2) rx_state_next = RX_START;
      end
      RX_START: begin
        if (timer == T_HALF) begin
          timer_next = '0;
          if (!rx_s2) begin
            rx_state_next = RX_DATA;
            bit_idx_next  = '0;
          end else begin
            rx_state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (timer == T_FULL) begin
          timer_next = '0;
          shreg_next = {rx_s2, shreg[7:1]};
          if (bit_idx == 3'd7) rx_state_next = RX_STOP;
          else                 bit_idx_next  = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (timer == T_FULL) begin
          timer_next = '0;
          if (rx_s2) begin
            byte_valid_next = 1'b1;
            rx_state_next   = RX_IDLE;
          end else begin
            fe_next       = 1'b1;
            rx_state_next = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        timer_next = '0;
        if (rx_s2) rx_state_next = RX_IDLE;
      end
      default: begin
        timer_next    = '0;
        rx_state_next = RX_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Framing
  // ---------------------------------------------------------------------
  frame_state_t f_state, f_state_next;
  logic [MEMORY_ADDRESS_BITS-1:0] addr, addr_next;
  logic                           we_next;
  logic [MEMORY_ADDRESS_BITS-1:0] wa_next;
  logic [5:0]                     wd_next;
  logic                           done_next, done_pend;

  // Frame state, address counter and registered RAM-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      f_state    <= F_HUNT;
      addr       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      f_state    <= f_state_next;
      addr       <= addr_next;
      wr_en      <= we_next;
      wr_addr    <= wa_next;
      wr_data    <= wd_next;
      busy       <= (f_state_next == F_LOAD);
      done_pend  <= done_next;
      frame_done <= done_pend;
    end
  end

  // Frame next-state: sync hunting, pixel writes, restart and drop
  always_comb begin
    f_state_next = f_state;
    addr_next    = addr;
    we_next      = 1'b0;
    wa_next      = '0;
    wd_next      = '0;
    done_next    = 1'b0;
    case (f_state)
      F_HUNT: begin
        if (byte_valid && shreg == SYNC_BYTE) begin
          f_state_next = F_LOAD;
          addr_next    = '0;
        end
      end
      F_LOAD: begin
        if (byte_valid) begin
          if (shreg[7:6] == 2'b00) begin
            we_next = 1'b1;
            wa_next = addr;
            wd_next = shreg[5:0];
            if (addr == LAST_ADDR) begin
              f_state_next = F_HUNT;
              addr_next    = '0;
              done_next    = 1'b1;
            end else begin
              addr_next = addr + MEMORY_ADDRESS_BITS'(1);
            end
          end else if (shreg == SYNC_BYTE) begin
            addr_next = '0;
          end
        end
      end
      default: f_state_next = F_HUNT;
    endcase
  end

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Directed testbench for uart_pixel_loader (DIV=10, 4x2 image).
module tb_uart_pixel_loader;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [5:0]  wr_data;
  logic        busy, frame_done, framing_error;

  int total  = 0;
  int passed = 0;

  logic [13:0] q_addr[$];
  logic [5:0]  q_data[$];
  int          q_time[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_bad = 0;
  int          fe_cnt = 0;
  logic        prev_last = 1'b0;

  uart_pixel_loader #(
    .CLK_HZ(1000000),
    .BAUD(100000),
    .IMAGE_SOURCE_X(4),
    .IMAGE_SOURCE_Y(2),
    .MEMORY_ADDRESS_BITS(14),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .frame_done(frame_done),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  // Monitor: record writes and pulse events on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_time.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      if (!prev_last) done_bad = done_bad + 1;
    end
    if (framing_error) fe_cnt = fe_cnt + 1;
    prev_last = wr_en && (wr_addr == 14'd7);
  end

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_time.delete();
    done_cnt = 0;
    done_bad = 0;
    fe_cnt   = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] v;
    v  = b;
    rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      idle(DIV);
    end
    rx = stop_bit;
    idle(DIV);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    total++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", wr_en); else passed++;
    total++; if (wr_addr !== 14'd0) $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); else passed++;
    total++; if (wr_data !== 6'd0) $display("FAIL rst_wr_data: got %0d want 0", wr_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else passed++;
    total++; if (framing_error !== 1'b0) $display("FAIL rst_framing_error: got %b want 0", framing_error); else passed++;
    clear_log();
    idle(200);
    total++; if (q_addr.size() != 0) $display("FAIL idle_writes: got %0d want 0", q_addr.size()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    total++; if (done_cnt + fe_cnt != 0) $display("FAIL idle_pulses: got %0d want 0", done_cnt + fe_cnt); else passed++;
  endtask

  task automatic test_frame();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    total++; if (busy !== 1'b1) $display("FAIL frame_busy_mid: got %b want 1", busy); else passed++;
    for (int i = 2; i < 8; i++) send_byte(8'(i), 1'b1);
    idle(10);
    total++; if (q_addr.size() != 8) $display("FAIL frame_count: got %0d want 8", q_addr.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i < q_addr.size()) begin
        total++;
        if (q_addr[i] !== 14'(i) || q_data[i] !== 6'(i))
          $display("FAIL frame_write%0d: got addr %0d data %0d want addr %0d data %0d", i, q_addr[i], q_data[i], i, i);
        else passed++;
        if (i > 0) begin
          total++;
          if (q_time[i] - q_time[i-1] != 100)
            $display("FAIL frame_spacing%0d: got %0d want 100", i, q_time[i] - q_time[i-1]);
          else passed++;
        end
      end
    end
    total++; if (done_cnt != 1) $display("FAIL frame_done_count: got %0d want 1", done_cnt); else passed++;
    total++; if (done_bad != 0) $display("FAIL frame_done_timing: got %0d misplaced want 0", done_bad); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL frame_busy_end: got %b want 0", busy); else passed++;
  endtask

  task automatic test_no_sync();
    clear_log();
    send_byte(8'h3F, 1'b1);
    idle(10);
    total++; if (q_addr.size() != 0) $display("FAIL nosync_writes: got %0d want 0", q_addr.size()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL nosync_busy: got %b want 0", busy); else passed++;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3F, 1'b1);
    idle(10);
    total++; if (q_addr.size() != 1) $display("FAIL sync_3f_count: got %0d want 1", q_addr.size()); else passed++;
    if (q_addr.size() > 0) begin
      total++;
      if (q_addr[0] !== 14'd0 || q_data[0] !== 6'h3F)
        $display("FAIL sync_3f_write: got addr %0d data %h want addr 0 data 3f", q_addr[0], q_data[0]);
      else passed++;
    end
  endtask

  task automatic test_restart();
    logic [13:0] ea[10];
    logic [5:0]  ed[10];
    ea[0] = 14'd0; ed[0] = 6'h01;
    ea[1] = 14'd1; ed[1] = 6'h02;
    for (int i = 0; i < 8; i++) begin
      ea[i+2] = 14'(i);
      ed[i+2] = 6'h15;
    end
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'h15, 1'b1);
    idle(10);
    total++; if (q_addr.size() != 10) $display("FAIL restart_count: got %0d want 10", q_addr.size()); else passed++;
    for (int i = 0; i < 10; i++) begin
      if (i < q_addr.size()) begin
        total++;
        if (q_addr[i] !== ea[i] || q_data[i] !== ed[i])
          $display("FAIL restart_write%0d: got addr %0d data %h want addr %0d data %h", i, q_addr[i], q_data[i], ea[i], ed[i]);
        else passed++;
      end
    end
    total++; if (done_cnt != 1) $display("FAIL restart_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_framing();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h2A, 1'b0);
    idle(20);
    total++; if (fe_cnt != 1) $display("FAIL ferr_count: got %0d want 1", fe_cnt); else passed++;
    total++; if (q_addr.size() != 0) $display("FAIL ferr_no_write: got %0d want 0", q_addr.size()); else passed++;
    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), 1'b1);
    idle(10);
    total++; if (q_addr.size() != 8) $display("FAIL ferr_frame_count: got %0d want 8", q_addr.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i < q_addr.size()) begin
        total++;
        if (q_addr[i] !== 14'(i) || q_data[i] !== 6'h30 + 6'(i))
          $display("FAIL ferr_write%0d: got addr %0d data %h want addr %0d data %h", i, q_addr[i], q_data[i], i, 6'h30 + 6'(i));
        else passed++;
      end
    end
    total++; if (fe_cnt != 1) $display("FAIL ferr_total: got %0d want 1", fe_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b1);
    total++; if (q_addr.size() != 3) $display("FAIL mid_pre_count: got %0d want 3", q_addr.size()); else passed++;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
    total++; if (wr_addr !== 14'd0) $display("FAIL mid_rst_addr: got %0d want 0", wr_addr); else passed++;
    clear_log();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'h08 + 8'(i), 1'b1);
    idle(10);
    total++; if (q_addr.size() != 8) $display("FAIL mid_frame_count: got %0d want 8", q_addr.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i < q_addr.size()) begin
        total++;
        if (q_addr[i] !== 14'(i) || q_data[i] !== 6'h08 + 6'(i))
          $display("FAIL mid_write%0d: got addr %0d data %h want addr %0d data %h", i, q_addr[i], q_data[i], i, 6'h08 + 6'(i));
        else passed++;
      end
    end
    total++; if (done_cnt != 1) $display("FAIL mid_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_glitch();
    clear_log();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(150);
    total++; if (q_addr.size() != 0) $display("FAIL glitch_writes: got %0d want 0", q_addr.size()); else passed++;
    total++; if (fe_cnt != 0) $display("FAIL glitch_ferr: got %0d want 0", fe_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else passed++;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h2C, 1'b1);
    idle(10);
    total++; if (q_addr.size() != 1) $display("FAIL glitch_recover_count: got %0d want 1", q_addr.size()); else passed++;
    if (q_addr.size() > 0) begin
      total++;
      if (q_addr[0] !== 14'd0 || q_data[0] !== 6'h2C)
        $display("FAIL glitch_recover_write: got addr %0d data %h want addr 0 data 2c", q_addr[0], q_data[0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_no_sync();
    test_restart();
    test_framing();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
